adpll_gain_scheduler: RTL and testbench
=======================================

Name: adpll_gain_scheduler

Overview:
Gear-shifting loop-gain controller for the ADPLL. It watches the ADPLL's signed phase error once per reference period. It drives the ADPLL enable and the dynamic kp/ki gain inputs: wide gains during acquisition, narrow gains during tracking. It also raises a lock flag and restarts the loop on acquisition timeout. It sits beside the ADPLL in the top level, on the 258 MHz fabric clock.

Parameters:
ERR_WIDTH, 8, width of signed error input
KP_WIDTH, 5, kp output width (matches ADPLL KP_WIDTH)
KI_WIDTH, 7, ki output width (matches ADPLL KI_WIDTH)
KP_ACQ, 5'b00100, kp during ACQUIRE
KI_ACQ, 7'b0000100, ki during ACQUIRE
KP_TRK, 5'b00001, kp during TRACK/LOCKED
KI_TRK, 7'b0000001, ki during TRACK/LOCKED
LOCK_THRESH, 2, |error| <= this counts as an in-band sample
UNLOCK_THRESH, 8, |error| > this counts as an out-of-band sample
LOCK_COUNT, 16, consecutive in-band samples per promotion step
UNLOCK_COUNT, 4, consecutive out-of-band samples to demote
TIMEOUT_SAMPLES, 1024, max samples in ACQUIRE before restart
RESTART_CYCLES, 16, clocks ADPLL enable held low on restart

Ports:
fpga_clk_i  in  1  fabric clock (258 MHz)
reset_i  in  1  asynchronous, active-high reset
enable_i  in  1  master run request
err_valid_i  in  1  one-cycle strobe: error_i holds a new sample
error_i  in  ERR_WIDTH  signed phase error from ADPLL
ovr_kp_i  in  KP_WIDTH  manual kp (optional feature)
ovr_ki_i  in  KI_WIDTH  manual ki (optional feature)
ovr_sel_i  in  1  select manual gains (optional feature)
adpll_enable_o  out  1  ADPLL enable
kp_o  out  KP_WIDTH  to ADPLL kp_i
ki_o  out  KI_WIDTH  to ADPLL ki_i
locked_o  out  1  loop locked
state_o  out  2  IDLE=0, ACQUIRE=1, TRACK=2, LOCKED=3 (RESTART reports 1)

Behaviour:
- Reset values, asynchronous: state IDLE; all counters 0; adpll_enable_o=0; kp_o=KP_ACQ; ki_o=KI_ACQ; locked_o=0.
- All outputs are registered. They reflect a transition on the clock edge after the cycle that causes it (latency 1).
- abs(error_i) saturates: the most-negative value (-128) maps to 127. Thresholds are compared unsigned on ERR_WIDTH-1 bits.
- Counters advance only on err_valid_i cycles. in_cnt and out_cnt clear on any sample that breaks their run. A sample between the thresholds clears both counters.
- IDLE: adpll_enable_o=0. enable_i=1 -> ACQUIRE.
- ACQUIRE: adpll_enable_o=1; gains ACQ.
  - in_cnt reaches LOCK_COUNT -> TRACK, counters cleared.
  - Otherwise, acq_cnt reaches TIMEOUT_SAMPLES -> RESTART.
  - Both on the same strobe -> TRACK wins.
- TRACK: gains TRK.
  - in_cnt reaches LOCK_COUNT -> LOCKED.
  - out_cnt reaches UNLOCK_COUNT -> ACQUIRE, with acq_cnt cleared.
- LOCKED: gains TRK; locked_o=1. out_cnt reaches UNLOCK_COUNT -> ACQUIRE; locked_o drops on the same edge.
- RESTART: adpll_enable_o=0 for exactly RESTART_CYCLES clocks, counted on every clock, not strobes. Then -> ACQUIRE with all counters cleared. err_valid_i is ignored in RESTART.
- enable_i=0 in any state: -> IDLE next edge, counters cleared. This overrides every other transition on the same cycle.
- Counters saturate; none wraps.

Optional Feature:
- Macro: ADPLL_GAIN_SCHED_OVERRIDE_EN.
- Defined: when ovr_sel_i=1, kp_o/ki_o follow registered ovr_kp_i/ovr_ki_i (1-cycle latency). The state machine and locked_o run unchanged.
- Undefined: ovr_* ports are present but ignored, and gains come from state only.

Decomposition:
- Shared package adpll_pkg holds the state encoding constants (IDLE/ACQUIRE/TRACK/LOCKED/RESTART) and default gain constants, so the top level and bench decode state_o identically.
- One sub-module, adpll_err_window. It is combinational abs-with-saturation plus threshold compare, producing in_band and out_band.
- The FSM and counters stay in the top module.

Test Plan:
1. Assert reset mid-LOCKED -> same cycle: adpll_enable_o=0, locked_o=0, kp_o=5'b00100, ki_o=7'b0000100, state_o=0.
2. enable_i=1, then 32 strobes of error 0 -> state_o=2 after strobe 16 with kp_o=5'b00001; state_o=3 and locked_o=1 after strobe 32.
3. In ACQUIRE, 15 strobes of error 1, then error 5, then 15 of error 0 -> still ACQUIRE; the 16th zero -> TRACK.
4. In LOCKED, 3 strobes of -20 then one of 0 -> stays LOCKED. Then 4 strobes of +20 -> ACQUIRE, locked_o=0, gains ACQ.
5. Constant error 50 for 1024 strobes -> RESTART: adpll_enable_o low for exactly 16 clocks, then high in ACQUIRE. Also drop enable_i on the same cycle as strobe 16 of a TRACK promotion -> IDLE.
6. error -128 in TRACK for 4 strobes -> treated as |127|, demote to ACQUIRE. With ADPLL_GAIN_SCHED_OVERRIDE_EN, ovr_sel_i=1 and ovr_kp_i=5'b01010 -> kp_o=5'b01010 next cycle regardless of state.

Source files
------------

// File: rtl/adpll_pkg.sv
// Shared state encoding and default loop gains for the ADPLL gain scheduler.
// Used by the RTL and the bench, so both decode state_o the same way.
package adpll_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACQUIRE = 3'd1,
        S_TRACK   = 3'd2,
        S_LOCKED  = 3'd3,
        S_RESTART = 3'd4
    } state_e;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_TRACK   = 2'd2;
    localparam logic [1:0] ST_LOCKED  = 2'd3;

    localparam logic [4:0] KP_ACQ_DEF = 5'b00100;
    localparam logic [6:0] KI_ACQ_DEF = 7'b0000100;
    localparam logic [4:0] KP_TRK_DEF = 5'b00001;
    localparam logic [6:0] KI_TRK_DEF = 7'b0000001;

    // RESTART is an acquisition sub-phase as far as the outside world is concerned.
    function automatic logic [1:0] state_code(input state_e s);
        case (s)
            S_IDLE:   state_code = ST_IDLE;
            S_TRACK:  state_code = ST_TRACK;
            S_LOCKED: state_code = ST_LOCKED;
            default:  state_code = ST_ACQUIRE;
        endcase
    endfunction

endpackage

// File: rtl/adpll_err_window.sv
// Saturating |error| and lock/unlock window classification; purely combinational.
// No latency, no flow control: result is valid whenever error_i is.
module adpll_err_window #(
    parameter int ERR_WIDTH     = 8,
    parameter int LOCK_THRESH   = 2,
    parameter int UNLOCK_THRESH = 8
) (
    input  logic [ERR_WIDTH-1:0] error_i,
    output logic                 in_band_o,
    output logic                 out_band_o
);

    localparam int MAG_W = ERR_WIDTH - 1;

    logic [MAG_W-1:0] neg_mag;
    logic [MAG_W-1:0] mag;

    always_comb begin
        neg_mag = ~error_i[MAG_W-1:0] + 1'b1;
        if (!error_i[ERR_WIDTH-1]) begin
            mag = error_i[MAG_W-1:0];
        end else if (error_i[MAG_W-1:0] == '0) begin
            // Most-negative input has no positive twin; clamp to the largest magnitude.
            mag = {MAG_W{1'b1}};
        end else begin
            mag = neg_mag;
        end
    end

    assign in_band_o  = (mag <= MAG_W'(LOCK_THRESH));
    assign out_band_o = (mag >  MAG_W'(UNLOCK_THRESH));

endmodule

// File: rtl/adpll_gain_scheduler.sv
// Gear-shifting ADPLL kp/ki scheduler with lock detect and acquisition-timeout restart; outputs registered (1 cycle).
// Optional manual gain override under ADPLL_GAIN_SCHED_OVERRIDE_EN; no backpressure, samples taken on err_valid_i strobes.
module adpll_gain_scheduler
    import adpll_pkg::*;
#(
    parameter int                  ERR_WIDTH       = 8,
    parameter int                  KP_WIDTH        = 5,
    parameter int                  KI_WIDTH        = 7,
    parameter logic [KP_WIDTH-1:0] KP_ACQ          = KP_ACQ_DEF,
    parameter logic [KI_WIDTH-1:0] KI_ACQ          = KI_ACQ_DEF,
    parameter logic [KP_WIDTH-1:0] KP_TRK          = KP_TRK_DEF,
    parameter logic [KI_WIDTH-1:0] KI_TRK          = KI_TRK_DEF,
    parameter int                  LOCK_THRESH     = 2,
    parameter int                  UNLOCK_THRESH   = 8,
    parameter int                  LOCK_COUNT      = 16,
    parameter int                  UNLOCK_COUNT    = 4,
    parameter int                  TIMEOUT_SAMPLES = 1024,
    parameter int                  RESTART_CYCLES  = 16
) (
    input  logic                 fpga_clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic                 err_valid_i,
    input  logic [ERR_WIDTH-1:0] error_i,
    input  logic [KP_WIDTH-1:0]  ovr_kp_i,
    input  logic [KI_WIDTH-1:0]  ovr_ki_i,
    input  logic                 ovr_sel_i,
    output logic                 adpll_enable_o,
    output logic [KP_WIDTH-1:0]  kp_o,
    output logic [KI_WIDTH-1:0]  ki_o,
    output logic                 locked_o,
    output logic [1:0]           state_o
);

    localparam int IN_W  = $clog2(LOCK_COUNT + 1);
    localparam int OUT_W = $clog2(UNLOCK_COUNT + 1);
    localparam int ACQ_W = $clog2(TIMEOUT_SAMPLES + 1);
    localparam int RST_W = $clog2(RESTART_CYCLES + 1);

    localparam logic [IN_W-1:0]  IN_MAX  = IN_W'(LOCK_COUNT);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(UNLOCK_COUNT);
    localparam logic [ACQ_W-1:0] ACQ_MAX = ACQ_W'(TIMEOUT_SAMPLES);
    localparam logic [RST_W-1:0] RST_MAX = RST_W'(RESTART_CYCLES);

    state_e             state_q, state_d;
    logic [IN_W-1:0]    in_cnt_q, in_cnt_d, in_nxt;
    logic [OUT_W-1:0]   out_cnt_q, out_cnt_d, out_nxt;
    logic [ACQ_W-1:0]   acq_cnt_q, acq_cnt_d, acq_nxt;
    logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d, rst_nxt;

    logic                adpll_en_q, adpll_en_d;
    logic [KP_WIDTH-1:0] kp_q, kp_d;
    logic [KI_WIDTH-1:0] ki_q, ki_d;
    logic                locked_q, locked_d;
    logic [1:0]          state_code_q, state_code_d;

    logic in_band;
    logic out_band;

    adpll_err_window #(
        .ERR_WIDTH    (ERR_WIDTH),
        .LOCK_THRESH  (LOCK_THRESH),
        .UNLOCK_THRESH(UNLOCK_THRESH)
    ) u_err_window (
        .error_i   (error_i),
        .in_band_o (in_band),
        .out_band_o(out_band)
    );

    // Run lengths saturate; a sample outside a run's band restarts that run.
    always_comb begin
        in_nxt  = '0;
        out_nxt = '0;
        if (in_band) begin
            in_nxt = (in_cnt_q == IN_MAX) ? in_cnt_q : in_cnt_q + 1'b1;
        end
        if (out_band) begin
            out_nxt = (out_cnt_q == OUT_MAX) ? out_cnt_q : out_cnt_q + 1'b1;
        end
        acq_nxt = (acq_cnt_q == ACQ_MAX) ? acq_cnt_q : acq_cnt_q + 1'b1;
        rst_nxt = (rst_cnt_q == RST_MAX) ? rst_cnt_q : rst_cnt_q + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        acq_cnt_d = acq_cnt_q;
        rst_cnt_d = rst_cnt_q;

        if (!enable_i) begin
            state_d   = S_IDLE;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            acq_cnt_d = '0;
            rst_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d   = S_ACQUIRE;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    acq_cnt_d = '0;
                    rst_cnt_d = '0;
                end
                S_ACQUIRE: begin
                    if (err_valid_i) begin
                        in_cnt_d  = in_nxt;
                        out_cnt_d = out_nxt;
                        acq_cnt_d = acq_nxt;
                        if (in_nxt == IN_MAX) begin
                            state_d   = S_TRACK;
                            in_cnt_d  = '0;
                            out_cnt_d = '0;
                            acq_cnt_d = '0;
                        end else if (acq_nxt == ACQ_MAX) begin
                            state_d   = S_RESTART;
                            in_cnt_d  = '0;
                            out_cnt_d = '0;
                            acq_cnt_d = '0;
                            rst_cnt_d = '0;
                        end
                    end
                end
                S_TRACK, S_LOCKED: begin
                    if (err_valid_i) begin
                        in_cnt_d  = in_nxt;
                        out_cnt_d = out_nxt;
                        if (state_q == S_TRACK && in_nxt == IN_MAX) begin
                            state_d   = S_LOCKED;
                            in_cnt_d  = '0;
                            out_cnt_d = '0;
                        end else if (out_nxt == OUT_MAX) begin
                            state_d   = S_ACQUIRE;
                            in_cnt_d  = '0;
                            out_cnt_d = '0;
                            acq_cnt_d = '0;
                        end
                    end
                end
                S_RESTART: begin
                    rst_cnt_d = rst_nxt;
                    if (rst_nxt == RST_MAX) begin
                        state_d   = S_ACQUIRE;
                        in_cnt_d  = '0;
                        out_cnt_d = '0;
                        acq_cnt_d = '0;
                        rst_cnt_d = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the transition edge.
    always_comb begin
        adpll_en_d   = (state_d == S_ACQUIRE) || (state_d == S_TRACK) || (state_d == S_LOCKED);
        locked_d     = (state_d == S_LOCKED);
        state_code_d = state_code(state_d);
        kp_d         = KP_ACQ;
        ki_d         = KI_ACQ;
        if (state_d == S_TRACK || state_d == S_LOCKED) begin
            kp_d = KP_TRK;
            ki_d = KI_TRK;
        end
`ifdef ADPLL_GAIN_SCHED_OVERRIDE_EN
        if (ovr_sel_i) begin
            kp_d = ovr_kp_i;
            ki_d = ovr_ki_i;
        end
`endif
    end

`ifndef ADPLL_GAIN_SCHED_OVERRIDE_EN
    logic ovr_unused;
    assign ovr_unused = ^{ovr_kp_i, ovr_ki_i, ovr_sel_i};
`endif

    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            acq_cnt_q    <= '0;
            rst_cnt_q    <= '0;
            adpll_en_q   <= 1'b0;
            kp_q         <= KP_ACQ;
            ki_q         <= KI_ACQ;
            locked_q     <= 1'b0;
            state_code_q <= ST_IDLE;
        end else begin
            state_q      <= state_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            acq_cnt_q    <= acq_cnt_d;
            rst_cnt_q    <= rst_cnt_d;
            adpll_en_q   <= adpll_en_d;
            kp_q         <= kp_d;
            ki_q         <= ki_d;
            locked_q     <= locked_d;
            state_code_q <= state_code_d;
        end
    end

    assign adpll_enable_o = adpll_en_q;
    assign kp_o           = kp_q;
    assign ki_o           = ki_q;
    assign locked_o       = locked_q;
    assign state_o        = state_code_q;

endmodule

// File: tb/tb_adpll_gain_scheduler.sv
// Bench for adpll_gain_scheduler: directed scenarios plus random traffic,
// every cycle compared against a sample-level behavioural model.
`timescale 1ns/1ps
module tb_adpll_gain_scheduler;
    import adpll_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       vld = 1'b0;
    logic [7:0] err = 8'd0;
    logic [4:0] ovr_kp = 5'd0;
    logic [6:0] ovr_ki = 7'd0;
    logic       ovr_sel = 1'b0;

    logic       adpll_enable_o;
    logic [4:0] kp_o;
    logic [6:0] ki_o;
    logic       locked_o;
    logic [1:0] state_o;

    adpll_gain_scheduler dut (
        .fpga_clk_i    (clk),
        .reset_i       (rst),
        .enable_i      (en),
        .err_valid_i   (vld),
        .error_i       (err),
        .ovr_kp_i      (ovr_kp),
        .ovr_ki_i      (ovr_ki),
        .ovr_sel_i     (ovr_sel),
        .adpll_enable_o(adpll_enable_o),
        .kp_o          (kp_o),
        .ki_o          (ki_o),
        .locked_o      (locked_o),
        .state_o       (state_o)
    );

    always #2 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: 0 idle, 1 acquire, 2 track, 3 locked, 4 restart; plain integer run lengths.
    int         m_state, m_in, m_out, m_acq, m_rst;
    logic       m_sel;
    logic [4:0] m_okp;
    logic [6:0] m_oki;

    task automatic model_reset();
        m_state = 0; m_in = 0; m_out = 0; m_acq = 0; m_rst = 0;
        m_sel = 1'b0; m_okp = '0; m_oki = '0;
    endtask

    task automatic model_clear();
        m_in = 0; m_out = 0; m_acq = 0; m_rst = 0;
    endtask

    task automatic model_step(input logic e, input logic v, input logic [7:0] x);
        int a;
        m_sel = ovr_sel; m_okp = ovr_kp; m_oki = ovr_ki;
        if (!e) begin
            m_state = 0;
            model_clear();
            return;
        end
        if (m_state == 0) begin
            m_state = 1;
            model_clear();
        end else if (m_state == 4) begin
            m_rst++;
            if (m_rst == 16) begin
                m_state = 1;
                model_clear();
            end
        end else if (v) begin
            a = int'($signed(x));
            if (a < 0) a = -a;
            if (a > 127) a = 127;
            m_in  = (a <= 2) ? ((m_in  < 16) ? m_in  + 1 : 16) : 0;
            m_out = (a > 8)  ? ((m_out < 4)  ? m_out + 1 : 4)  : 0;
            if (m_state == 1) begin
                if (m_acq < 1024) m_acq++;
                if (m_in == 16) begin
                    m_state = 2; model_clear();
                end else if (m_acq == 1024) begin
                    m_state = 4; model_clear();
                end
            end else if (m_state == 2 && m_in == 16) begin
                m_state = 3; model_clear();
            end else if (m_out == 4) begin
                m_state = 1; model_clear();
            end
        end
    endtask

    function automatic logic [15:0] exp_outs();
        logic [1:0] code;
        logic       e, l;
        logic [4:0] kp;
        logic [6:0] ki;
        code = (m_state == 4) ? ST_ACQUIRE : 2'(m_state);
        e    = (m_state >= 1 && m_state <= 3);
        l    = (m_state == 3);
        kp   = (m_state == 2 || m_state == 3) ? KP_TRK_DEF : KP_ACQ_DEF;
        ki   = (m_state == 2 || m_state == 3) ? KI_TRK_DEF : KI_ACQ_DEF;
`ifdef ADPLL_GAIN_SCHED_OVERRIDE_EN
        if (m_sel) begin
            kp = m_okp;
            ki = m_oki;
        end
`endif
        return {code, e, l, kp, ki};
    endfunction

    task automatic tick(input logic e, input logic v, input logic [7:0] x);
        en = e; vld = v; err = x;
        @(posedge clk);
        model_step(e, v, x);
        @(negedge clk);
        check("outs", {state_o, adpll_enable_o, locked_o, kp_o, ki_o}, exp_outs());
    endtask

    function automatic logic [7:0] rand_err();
        int r;
        logic [7:0] edges [12];
        edges = '{8'd2, 8'd3, 8'd8, 8'd9, 8'hFE, 8'hFD, 8'hF8, 8'hF7, 8'h80, 8'h7F, 8'd1, 8'hFF};
        r = $urandom_range(0, 99);
        if (r < 75) return 8'($urandom_range(0, 4)) - 8'd2;
        if (r < 90) return edges[$urandom_range(0, 11)];
        return 8'($urandom);
    endfunction

    initial begin
        int lowcnt;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_outs", {state_o, adpll_enable_o, locked_o, kp_o, ki_o},
              {ST_IDLE, 1'b0, 1'b0, KP_ACQ_DEF, KI_ACQ_DEF});
        rst = 1'b0;
        tick(1'b0, 1'b0, 8'd0);

        // Acquisition to lock with a clean error.
        tick(1'b1, 1'b0, 8'd0);
        for (int i = 1; i <= 32; i++) begin
            tick(1'b1, 1'b1, 8'd0);
            if (i == 16) begin
                check("track_state", state_o, ST_TRACK);
                check("track_kp", kp_o, KP_TRK_DEF);
            end
        end
        check("lock_state", state_o, ST_LOCKED);
        check("lock_flag", locked_o, 1'b1);

        // Interrupted out-of-band run, then a full one.
        repeat (3) tick(1'b1, 1'b1, 8'hEC);
        tick(1'b1, 1'b1, 8'd0);
        check("lock_hold", state_o, ST_LOCKED);
        repeat (4) tick(1'b1, 1'b1, 8'd20);
        check("demote_state", state_o, ST_ACQUIRE);
        check("demote_lock", locked_o, 1'b0);
        check("demote_gains", {kp_o, ki_o}, {KP_ACQ_DEF, KI_ACQ_DEF});

        // Mid-window sample breaks the in-band run.
        repeat (15) tick(1'b1, 1'b1, 8'd1);
        tick(1'b1, 1'b1, 8'd5);
        repeat (15) tick(1'b1, 1'b1, 8'd0);
        check("window_reset", state_o, ST_ACQUIRE);
        tick(1'b1, 1'b1, 8'd0);
        check("window_track", state_o, ST_TRACK);

        // Most-negative error counts as out of band.
        repeat (4) tick(1'b1, 1'b1, 8'h80);
        check("neg_sat_demote", state_o, ST_ACQUIRE);

        // Acquisition timeout and restart pulse width.
        for (int i = 0; i < 1024; i++) begin
            repeat ($urandom_range(0, 1)) tick(1'b1, 1'b0, 8'd50);
            tick(1'b1, 1'b1, 8'd50);
        end
        check("restart_enable", adpll_enable_o, 1'b0);
        check("restart_code", state_o, ST_ACQUIRE);
        lowcnt = 1;
        for (int i = 0; i < 40 && !adpll_enable_o; i++) begin
            tick(1'b1, 1'b1, 8'($urandom));
            if (!adpll_enable_o) lowcnt++;
        end
        check("restart_len", lowcnt, 16);
        check("restart_resume", {state_o, adpll_enable_o}, {ST_ACQUIRE, 1'b1});

        // Disable wins over the promotion strobe.
        repeat (15) tick(1'b1, 1'b1, 8'd0);
        tick(1'b0, 1'b1, 8'd0);
        check("disable_wins", {state_o, adpll_enable_o}, {ST_IDLE, 1'b0});

        // Asynchronous reset while locked.
        tick(1'b1, 1'b0, 8'd0);
        repeat (32) tick(1'b1, 1'b1, 8'd0);
        check("relock", locked_o, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("arst_enable", adpll_enable_o, 1'b0);
        check("arst_lock", locked_o, 1'b0);
        check("arst_kp", kp_o, KP_ACQ_DEF);
        check("arst_ki", ki_o, KI_ACQ_DEF);
        check("arst_state", state_o, ST_IDLE);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

`ifdef ADPLL_GAIN_SCHED_OVERRIDE_EN
        tick(1'b1, 1'b0, 8'd0);
        ovr_sel = 1'b1; ovr_kp = 5'b01010; ovr_ki = 7'h33;
        tick(1'b1, 1'b0, 8'd0);
        check("ovr_kp", kp_o, 5'b01010);
        check("ovr_state", state_o, ST_ACQUIRE);
        ovr_sel = 1'b0;
`endif

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
`ifdef ADPLL_GAIN_SCHED_OVERRIDE_EN
            ovr_sel = ($urandom_range(0, 7) == 0);
            ovr_kp  = 5'($urandom);
            ovr_ki  = 7'($urandom);
`endif
            tick($urandom_range(0, 299) != 0, $urandom_range(0, 3) != 0, rand_err());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
